// File: rtl/fetch_unit.sv
// Instruction fetch front-end: sequential word fetches on a request/grant bus,
// a small {pc, instr} FIFO to decode, and redirect with stale-response discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc, resp_pc;
    logic [CW-1:0] count, outstanding, discard;
    logic [CW-1:0] count_n, outstanding_n;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          req_q, req_n;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    logic gnt, rsp, drop, push, pop;
    logic [31:0] redirect_pc;

    assign gnt         = req_q & mem_gnt_i;
    assign rsp         = mem_rvalid_i & (outstanding != '0);
    assign drop        = rsp & (discard != '0);
    assign push        = rsp & ~drop;
    assign pop         = (count != '0) & instr_ready_i;
    assign redirect_pc = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        outstanding_n = outstanding + CW'(gnt) - CW'(rsp);
        count_n       = count + CW'(push) - CW'(pop);
        if (redirect_i) begin
            count_n = '0;
        end
        // request credit is evaluated on next-state values so the output stays registered
        req_n = ({1'b0, count_n} + {1'b0, outstanding_n}) < (CW+1)'(DEPTH);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            req_q       <= 1'b0;
        end else begin
            outstanding <= outstanding_n;
            count       <= count_n;
            req_q       <= req_n;
            if (redirect_i) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                discard  <= outstanding_n;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (gnt) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (drop) begin
                    discard <= discard - CW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= mem_rdata_i;
        end
    end

    assign mem_req_o     = req_q;
    assign mem_addr_o    = fetch_pc;
    assign instr_valid_o = (count != '0);
    assign instr_o       = fifo_instr[rd_ptr];
    assign instr_pc_o    = fifo_pc[rd_ptr];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable latency and a
// scoreboard of expected {pc, instr} refilled at every reset and redirect.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    pend_t       pend[$];
    exp_t        sb[$];
    logic [31:0] gnt_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    int n_gnt    = 0;
    int hs_cnt   = 0;
    int first_gnt = -1;
    int first_vld = -1;
    logic gnt_en   = 1'b1;
    logic ready_en = 1'b1;
    logic redir    = 1'b0;
    logic [31:0] redir_pc = '0;
    logic last_gnt, last_rsp;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        sb.delete();
        for (int i = 0; i < 128; i++) begin
            sb.push_back('{pc + 32'(i * 4), memf(pc + 32'(i * 4))});
        end
    endtask

    // one clock cycle, entered and left at a falling edge
    task automatic cycle();
        exp_t e;
        last_rsp = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memf(pend[0].addr);
            void'(pend.pop_front());
            last_rsp = 1'b1;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end
        mem_gnt     = gnt_en;
        instr_ready = ready_en;
        redirect    = redir;
        redirect_pc = redir_pc;
        last_gnt = mem_req & mem_gnt;
        if (last_gnt) begin
            check("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            pend.push_back('{mem_addr, cyc + lat});
            gnt_log.push_back(mem_addr);
            n_gnt++;
            if (first_gnt < 0) first_gnt = cyc;
            n_checks++;
            assert (pend.size() <= 4) else begin
                n_fail++;
                $error("FAIL credit: observed %0d in flight expected <= 4", pend.size());
            end
        end
        if (instr_valid && first_vld < 0) first_vld = cyc;
        if (instr_valid && instr_ready) begin
            hs_cnt++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_empty: observed pc %h expected no instruction", instr_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.ins);
            end
        end
        if (redir) sb_restart({redir_pc[31:2], 2'b00});
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redir    = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        redirect   = 1'b0;
        pend.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        cyc = 0; n_gnt = 0; hs_cnt = 0; first_gnt = -1; first_vld = -1;
        gnt_log.delete();
        sb_restart(32'h0);
    endtask

    task automatic drain();
        gnt_en = 1'b0;
        ready_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (pend.size() == 0 && !instr_valid) break;
            cycle();
        end
        check("drained", {31'd0, (pend.size() == 0 && !instr_valid)}, 32'd1);
    endtask

    initial begin
        int nreq, g0, h0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b1;
        @(negedge clk);

        // streaming from reset with a 1-cycle memory
        lat = 1; gnt_en = 1'b1; ready_en = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) cycle();
        check("first_lat", 32'(first_vld - first_gnt), 32'd2);
        check("stream_cnt", 32'(hs_cnt), 32'd17);

        // decode stalled: credit limits fetch to four
        ready_en = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle();
        check("full_gnts", 32'(n_gnt), 32'd4);
        check("full_req", {31'd0, mem_req}, 32'd0);
        check("full_valid", {31'd0, instr_valid}, 32'd1);

        // grant withheld: address holds at 0x10
        gnt_en = 1'b0; ready_en = 1'b1; nreq = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req) begin
                check("stall_addr", mem_addr, 32'h10);
                nreq++;
            end
            cycle();
        end
        check("stall_cycles", 32'(nreq), 32'd3);
        gnt_en = 1'b1;
        check("stall_req", {31'd0, mem_req}, 32'd1);
        cycle();
        check("after_gnt_addr", mem_addr, 32'h14);
        check("resume_addr", gnt_log[4], 32'h10);
        for (int i = 0; i < 15; i++) cycle();
        check("resume_cnt", 32'(hs_cnt >= 10), 32'd1);

        // redirect with two fetches in flight on a 3-cycle memory
        drain();
        lat = 3; g0 = n_gnt;
        gnt_en = 1'b1;
        cycle();
        cycle();
        gnt_en = 1'b0;
        check("inflight_gnts", 32'(n_gnt - g0), 32'd2);
        redir = 1'b1; redir_pc = 32'h0000_0102;
        cycle();
        check("redir_addr", mem_addr, 32'h100);
        check("redir_req", {31'd0, mem_req}, 32'd1);
        check("redir_valid", {31'd0, instr_valid}, 32'd0);
        gnt_en = 1'b1; h0 = hs_cnt;
        for (int i = 0; i < 20; i++) cycle();
        check("redir_stream", 32'(hs_cnt - h0 >= 5), 32'd1);

        // redirect coinciding with a grant and a response
        drain();
        lat = 1; gnt_en = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        redir = 1'b1; redir_pc = 32'h0000_0200;
        cycle();
        check("coinc_gnt", {31'd0, last_gnt}, 32'd1);
        check("coinc_rsp", {31'd0, last_rsp}, 32'd1);
        check("coinc_valid", {31'd0, instr_valid}, 32'd0);
        check("coinc_addr", mem_addr, 32'h200);
        h0 = hs_cnt;
        for (int i = 0; i < 15; i++) cycle();
        check("coinc_stream", 32'(hs_cnt - h0 >= 8), 32'd1);

        // reset mid-stream with the FIFO full
        ready_en = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        ready_en = 1'b1;
        do_reset();
        for (int i = 0; i < 15; i++) cycle();
        check("post_rst_first", gnt_log[0], 32'h0);
        check("post_rst_cnt", 32'(hs_cnt), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
